// File: rtl/count_core_pkg.sv
// ----------------------------------------------------------------------------
// count_core_pkg
// Shared definitions for one 8253 counter channel's count engine.
//   mode_e   : the six 8253 counting modes MODE0..MODE5
//   state_e  : sequencing states IDLE / WAIT_N / LOAD / RUN
//   mapMode  : folds the raw 3-bit mode field onto mode_e (6 -> 2, 7 -> 3)
// ----------------------------------------------------------------------------
package count_core_pkg;

  typedef enum logic [2:0] {
    MODE0 = 3'd0,
    MODE1 = 3'd1,
    MODE2 = 3'd2,
    MODE3 = 3'd3,
    MODE4 = 3'd4,
    MODE5 = 3'd5
  } mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_N = 2'd1,
    LOAD   = 2'd2,
    RUN    = 2'd3
  } state_e;

  // The 8253 leaves codes 6 and 7 as don't-care aliases of the rate
  // generator and the square-wave generator.
  function automatic mode_e mapMode(input logic [2:0] raw);
    mode_e m;
    case (raw)
      3'd0:    m = MODE0;
      3'd1:    m = MODE1;
      3'd2:    m = MODE2;
      3'd3:    m = MODE3;
      3'd4:    m = MODE4;
      3'd5:    m = MODE5;
      3'd6:    m = MODE2;
      default: m = MODE3;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/count_core_gate_edge.sv
// ----------------------------------------------------------------------------
// gate_edge
// Rising-edge detector for the (already synchronised) GATE pin.
//   i_clk        : system clock
//   i_rst        : synchronous reset, active-high
//   i_gate       : GATE level
//   o_gate_rise  : high in the cycle where GATE is 1 and was 0 one clock earlier
// ----------------------------------------------------------------------------
module gate_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_gate,
  output logic o_gate_rise
);

  logic r_gateQ;

  // Keep last cycle's GATE level so a 0 -> 1 transition can be spotted.
  // Sampled every clock, independent of the count strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_gateQ <= 1'b0;
    end else begin
      r_gateQ <= i_gate;
    end
  end

  assign o_gate_rise = i_gate & ~r_gateQ;

endmodule

// File: rtl/count_core.sv
// ----------------------------------------------------------------------------
// count_core
// Count engine of one 8253 counter channel: mode register, WIDTH-bit down
// counter, gate trigger latch and the per-mode sequencing that produces the
// flag set consumed by the channel's output generator (OUT = f(flags)).
//   i_clk      : system clock
//   i_rst      : synchronous reset, active-high, beats every strobe
//   i_ce       : count strobe, one pulse per 8253 CLK falling edge
//   i_gate     : GATE pin, already synchronised
//   i_mode_wr  : strobe, write i_mode_in
//   i_mode_in  : mode 0..5 (6 -> 2, 7 -> 3)
//   i_cnt_wr   : strobe, write initial count i_cnt_in
//   i_cnt_in   : initial count N (0 means 2**WIDTH)
//   o_valid    : a mode has been programmed
//   o_p1       : square-wave mode, OUT follows o_ch
//   o_p2       : rate-generator mode, OUT follows o_c1
//   o_os       : one-shot family (modes 0,1,4,5)
//   o_osa      : count written since the last mode write
//   o_c1       : output level for modes 0,1,2,4,5
//   o_ch       : square-wave phase, 1 = high half
//   o_count    : live counter value
// ----------------------------------------------------------------------------
module count_core
  import count_core_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ce,
  input  logic             i_gate,
  input  logic             i_mode_wr,
  input  logic [2:0]       i_mode_in,
  input  logic             i_cnt_wr,
  input  logic [WIDTH-1:0] i_cnt_in,
  output logic             o_valid,
  output logic             o_p1,
  output logic             o_p2,
  output logic             o_os,
  output logic             o_osa,
  output logic             o_c1,
  output logic             o_ch,
  output logic [WIDTH-1:0] o_count
);

  state_e           r_state;
  mode_e            r_mode;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_count;
  logic             r_valid;
  logic             r_osa;
  logic             r_c1;
  logic             r_ch;
  logic             r_trig;

  logic             w_gateRise;
  mode_e            w_newMode;
  logic             w_isPeriodic;
  logic             w_isTrigMode;
  logic [WIDTH:0]   w_nFull;
  logic [WIDTH:0]   w_nPeriodic;
  logic [WIDTH:0]   w_half;
  logic [WIDTH:0]   w_cntFull;
  logic [WIDTH:0]   w_cntNextFull;
  logic [WIDTH-1:0] w_cntDec;
  logic [WIDTH-1:0] w_loadVal;

  gate_edge u_gateEdge (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_gate      (i_gate),
    .o_gate_rise (w_gateRise)
  );

  // Derived quantities used by the sequencer. Counts are widened by one bit
  // so that a stored 0 can stand for 2**WIDTH in the square-wave half-period
  // arithmetic. Periodic modes cannot run with N=1, so it is stretched to 2.
  always_comb begin
    w_newMode     = mapMode(i_mode_in);
    w_isPeriodic  = (r_mode == MODE2) || (r_mode == MODE3);
    w_isTrigMode  = (r_mode == MODE1) || (r_mode == MODE5);
    w_nFull       = (r_n == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, r_n};
    w_nPeriodic   = (w_nFull == (WIDTH+1)'(1)) ? (WIDTH+1)'(2) : w_nFull;
    w_half        = w_nPeriodic >> 1;
    w_cntFull     = (r_count == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, r_count};
    w_cntNextFull = w_cntFull - (WIDTH+1)'(1);
    w_cntDec      = r_count - WIDTH'(1);
    w_loadVal     = w_isPeriodic ? w_nPeriodic[WIDTH-1:0] : r_n;
  end

  // Main sequencer: mode register, stored N, counter, flags and the gate
  // trigger latch all live here. A mode write always wins over the state
  // machine and aborts whatever was running; a count write in the same cycle
  // is then taken under the new mode. A count write never lets a ce in the
  // same cycle load it, so the first load always lands on a later ce.
  // The trigger latch is only consumed on a ce where it was already set,
  // which pushes a gate edge coincident with ce to the following ce.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_mode  <= MODE0;
      r_n     <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_osa   <= 1'b0;
      r_c1    <= 1'b0;
      r_ch    <= 1'b0;
      r_trig  <= 1'b0;
    end else begin
      if (i_mode_wr) begin
        r_mode  <= w_newMode;
        r_valid <= 1'b1;
        r_osa   <= 1'b0;
        r_state <= WAIT_N;
        r_c1    <= (w_newMode != MODE0);
        r_ch    <= 1'b1;
        r_trig  <= 1'b0;
        if (i_cnt_wr) begin
          r_n     <= i_cnt_in;
          r_osa   <= 1'b1;
          r_state <= LOAD;
          if (w_newMode == MODE0) begin
            r_c1 <= 1'b0;
          end
        end
      end else begin
        case (r_state)
          IDLE: begin
          end

          WAIT_N: begin
            if (i_cnt_wr) begin
              r_n     <= i_cnt_in;
              r_osa   <= 1'b1;
              r_state <= LOAD;
              if (r_mode == MODE0) begin
                r_c1 <= 1'b0;
              end
            end
          end

          LOAD: begin
            if (i_cnt_wr) begin
              r_n <= i_cnt_in;
              if (r_mode == MODE0) begin
                r_c1 <= 1'b0;
              end
            end else if (i_ce && (!w_isTrigMode || r_trig)) begin
              r_count <= w_loadVal;
              r_state <= RUN;
              r_trig  <= 1'b0;
              r_ch    <= 1'b1;
              r_c1    <= (r_mode != MODE0) && (r_mode != MODE1);
            end
          end

          RUN: begin
            if (i_cnt_wr) begin
              r_n <= i_cnt_in;
            end
            if (i_cnt_wr && ((r_mode == MODE0) || (r_mode == MODE4))) begin
              r_state <= LOAD;
              if (r_mode == MODE0) begin
                r_c1 <= 1'b0;
              end
            end else begin
              case (r_mode)
                MODE0: begin
                  if (i_ce && i_gate) begin
                    r_count <= w_cntDec;
                    if (r_count == WIDTH'(1)) begin
                      r_c1 <= 1'b1;
                    end
                  end
                end

                MODE4: begin
                  if (i_ce) begin
                    if (i_gate) begin
                      r_count <= w_cntDec;
                      r_c1    <= (r_count != WIDTH'(1));
                    end else begin
                      r_c1 <= 1'b1;
                    end
                  end
                end

                MODE1, MODE5: begin
                  if (i_ce) begin
                    if (r_trig) begin
                      r_count <= r_n;
                      r_trig  <= 1'b0;
                      r_c1    <= (r_mode == MODE5);
                    end else begin
                      r_count <= w_cntDec;
                      if (r_mode == MODE1) begin
                        if (r_count == WIDTH'(1)) begin
                          r_c1 <= 1'b1;
                        end
                      end else begin
                        r_c1 <= (r_count != WIDTH'(1));
                      end
                    end
                  end
                end

                MODE2: begin
                  if (!i_gate) begin
                    r_c1 <= 1'b1;
                  end else if (i_ce) begin
                    if (r_trig || (r_count == WIDTH'(1))) begin
                      r_count <= w_nPeriodic[WIDTH-1:0];
                      r_c1    <= 1'b1;
                      r_trig  <= 1'b0;
                    end else begin
                      r_count <= w_cntDec;
                      r_c1    <= (r_count != WIDTH'(2));
                    end
                  end
                end

                MODE3: begin
                  if (!i_gate) begin
                    r_ch <= 1'b1;
                  end else if (i_ce) begin
                    if (r_trig || (r_count == WIDTH'(1))) begin
                      r_count <= w_nPeriodic[WIDTH-1:0];
                      r_ch    <= 1'b1;
                      r_trig  <= 1'b0;
                    end else begin
                      r_count <= w_cntDec;
                      r_ch    <= (w_cntNextFull > w_half);
                    end
                  end
                end

                default: begin
                end
              endcase
            end
          end

          default: begin
            r_state <= IDLE;
          end
        endcase
      end

      if (w_gateRise) begin
        r_trig <= 1'b1;
      end
    end
  end

  // Mode-class flags are decoded from the registered mode and qualified by
  // valid so that a freshly reset channel shows every flag low.
  assign o_valid = r_valid;
  assign o_p1    = r_valid && (r_mode == MODE3);
  assign o_p2    = r_valid && (r_mode == MODE2);
  assign o_os    = r_valid && ((r_mode == MODE0) || (r_mode == MODE1) ||
                               (r_mode == MODE4) || (r_mode == MODE5));
  assign o_osa   = r_osa;
  assign o_c1    = r_c1;
  assign o_ch    = r_ch;
  assign o_count = r_count;

endmodule

// File: tb/tb_count_core.sv
// ----------------------------------------------------------------------------
// tb_count_core
// Self-checking bench for count_core: reset, a table of programmed-mode
// vectors, hand-written multi-cycle corner sequences and randomized trials
// against an arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_count_core;

  logic        i_clk;
  logic        i_rst;
  logic        i_ce;
  logic        i_gate;
  logic        i_mode_wr;
  logic [2:0]  i_mode_in;
  logic        i_cnt_wr;
  logic [15:0] i_cnt_in;
  logic        o_valid;
  logic        o_p1;
  logic        o_p2;
  logic        o_os;
  logic        o_osa;
  logic        o_c1;
  logic        o_ch;
  logic [15:0] o_count;

  int errors;
  int checks;

  typedef struct {
    logic [2:0]  mode;
    logic [15:0] n;
    int          numCe;
    logic [15:0] expCount;
    logic        expC1;
    logic        expCh;
    logic        expP1;
    logic        expP2;
    logic        expOs;
  } vec_t;

  vec_t vecs[14];

  count_core #(.WIDTH(16)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_ce      (i_ce),
    .i_gate    (i_gate),
    .i_mode_wr (i_mode_wr),
    .i_mode_in (i_mode_in),
    .i_cnt_wr  (i_cnt_wr),
    .i_cnt_in  (i_cnt_in),
    .o_valid   (o_valid),
    .o_p1      (o_p1),
    .o_p2      (o_p2),
    .o_os      (o_os),
    .o_osa     (o_osa),
    .o_c1      (o_c1),
    .o_ch      (o_ch),
    .o_count   (o_count)
  );

  // Free-running 100 MHz clock.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // One count strobe followed by an idle cycle.
  task automatic pulseCe();
    i_ce = 1'b1;
    step();
    i_ce = 1'b0;
    step();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Program a mode, then a count in the next cycle, with GATE high, then
  // give numCe count strobes.
  task automatic applyStimulus(input logic [2:0] mode, input logic [15:0] n, input int numCe);
    i_gate = 1'b1;
    step();
    i_mode_wr = 1'b1;
    i_mode_in = mode;
    step();
    i_mode_wr = 1'b0;
    i_cnt_wr  = 1'b1;
    i_cnt_in  = n;
    step();
    i_cnt_wr  = 1'b0;
    for (int i = 0; i < numCe; i++) begin
      pulseCe();
    end
  endtask

  // Reference behaviour for a channel started with GATE held high. j is the
  // number of strobes after the one that loaded N. Periodic modes repeat
  // with period e; one-shot counts simply run down modulo 2**16.
  function automatic void refModel(input int m, input int n, input int j,
                                   output int cnt, output int c1, output int ch);
    int e;
    int r;
    e = (n == 0) ? 65536 : n;
    if ((m == 2 || m == 3) && e == 1) e = 2;
    r = j % e;
    cnt = 0;
    c1 = 1;
    ch = 1;
    case (m)
      0: begin
        cnt = ((n - j) % 65536 + 65536) % 65536;
        c1  = (j >= e) ? 1 : 0;
      end
      2: begin
        cnt = (e - r) % 65536;
        c1  = (r != e - 1) ? 1 : 0;
      end
      3: begin
        cnt = (e - r) % 65536;
        ch  = (r < (e + 1) / 2) ? 1 : 0;
      end
      default: begin
        cnt = ((n - j) % 65536 + 65536) % 65536;
        c1  = (j != e) ? 1 : 0;
      end
    endcase
  endfunction

  int modeList[6];
  int rawMode;
  int mMode;
  int nVal;
  int kVal;
  int eCnt;
  int eC1;
  int eCh;
  int expCnt[6];
  int expC1[6];

  initial begin
    errors    = 0;
    checks    = 0;
    i_rst     = 1'b1;
    i_ce      = 1'b1;
    i_gate    = 1'b1;
    i_mode_wr = 1'b1;
    i_mode_in = 3'd2;
    i_cnt_wr  = 1'b1;
    i_cnt_in  = 16'd7;

    vecs[0]  = '{3'd0, 16'd4, 1, 16'd4,    1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{3'd0, 16'd4, 5, 16'd0,    1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{3'd0, 16'd4, 6, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{3'd2, 16'd3, 3, 16'd1,    1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{3'd2, 16'd3, 4, 16'd3,    1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{3'd2, 16'd1, 2, 16'd1,    1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{3'd3, 16'd5, 3, 16'd3,    1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{3'd3, 16'd5, 4, 16'd2,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{3'd3, 16'd4, 3, 16'd2,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{3'd4, 16'd2, 3, 16'd0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{3'd4, 16'd2, 4, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{3'd6, 16'd3, 2, 16'd2,    1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{3'd7, 16'd2, 2, 16'd1,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{3'd3, 16'd1, 2, 16'd1,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset held for two cycles with every strobe asserted.
    step();
    step();
    i_rst     = 1'b0;
    i_ce      = 1'b0;
    i_mode_wr = 1'b0;
    i_cnt_wr  = 1'b0;
    checkOutput("reset valid", o_valid, 0);
    checkOutput("reset p1", o_p1, 0);
    checkOutput("reset p2", o_p2, 0);
    checkOutput("reset os", o_os, 0);
    checkOutput("reset osa", o_osa, 0);
    checkOutput("reset c1", o_c1, 0);
    checkOutput("reset ch", o_ch, 0);
    checkOutput("reset count", o_count, 0);
    pulseCe();
    pulseCe();
    checkOutput("idle count", o_count, 0);
    checkOutput("idle valid", o_valid, 0);

    $display("[TB] table vectors");
    for (int v = 0; v < 14; v++) begin
      applyStimulus(vecs[v].mode, vecs[v].n, vecs[v].numCe);
      checkOutput($sformatf("vec%0d count", v), o_count, vecs[v].expCount);
      checkOutput($sformatf("vec%0d c1", v), o_c1, vecs[v].expC1);
      checkOutput($sformatf("vec%0d ch", v), o_ch, vecs[v].expCh);
      checkOutput($sformatf("vec%0d p1", v), o_p1, vecs[v].expP1);
      checkOutput($sformatf("vec%0d p2", v), o_p2, vecs[v].expP2);
      checkOutput($sformatf("vec%0d os", v), o_os, vecs[v].expOs);
      checkOutput($sformatf("vec%0d osa", v), o_osa, 1);
      checkOutput($sformatf("vec%0d valid", v), o_valid, 1);
    end

    $display("[TB] mode 2 gate freeze");
    applyStimulus(3'd2, 16'd3, 3);
    checkOutput("m2 low c1", o_c1, 0);
    i_gate = 1'b0;
    step();
    checkOutput("m2 gate0 c1", o_c1, 1);
    pulseCe();
    pulseCe();
    checkOutput("m2 frozen count", o_count, 1);
    checkOutput("m2 frozen c1", o_c1, 1);
    i_gate = 1'b1;
    step();
    pulseCe();
    checkOutput("m2 gate reload count", o_count, 3);
    checkOutput("m2 gate reload c1", o_c1, 1);
    pulseCe();
    checkOutput("m2 after reload count", o_count, 2);

    $display("[TB] mode 1 retrigger");
    i_gate = 1'b0;
    step();
    i_mode_wr = 1'b1;
    i_mode_in = 3'd1;
    step();
    i_mode_wr = 1'b0;
    i_cnt_wr  = 1'b1;
    i_cnt_in  = 16'd3;
    step();
    i_cnt_wr  = 1'b0;
    checkOutput("m1 armed osa", o_osa, 1);
    checkOutput("m1 os", o_os, 1);
    pulseCe();
    pulseCe();
    checkOutput("m1 untriggered c1", o_c1, 1);
    i_gate = 1'b1;
    step();
    checkOutput("m1 trig pending c1", o_c1, 1);
    expCnt = '{3, 2, 3, 2, 1, 0};
    expC1  = '{0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        i_gate = 1'b0;
        step();
        i_gate = 1'b1;
        step();
      end
      pulseCe();
      checkOutput($sformatf("m1 ce%0d count", i + 1), o_count, expCnt[i]);
      checkOutput($sformatf("m1 ce%0d c1", i + 1), o_c1, expC1[i]);
    end

    $display("[TB] mode 1 trigger coincident with ce");
    i_gate = 1'b0;
    step();
    i_mode_wr = 1'b1;
    i_mode_in = 3'd1;
    i_cnt_wr  = 1'b1;
    i_cnt_in  = 16'd2;
    step();
    i_mode_wr = 1'b0;
    i_cnt_wr  = 1'b0;
    step();
    i_gate = 1'b1;
    i_ce   = 1'b1;
    step();
    i_ce   = 1'b0;
    step();
    checkOutput("m1 coincident no load c1", o_c1, 1);
    pulseCe();
    checkOutput("m1 deferred load count", o_count, 2);
    checkOutput("m1 deferred load c1", o_c1, 0);

    $display("[TB] mode 0 rewrite during run");
    applyStimulus(3'd0, 16'd2, 3);
    checkOutput("m0 terminal c1", o_c1, 1);
    i_cnt_wr = 1'b1;
    i_cnt_in = 16'd5;
    step();
    i_cnt_wr = 1'b0;
    checkOutput("m0 rewrite c1", o_c1, 0);
    pulseCe();
    checkOutput("m0 restart count", o_count, 5);

    $display("[TB] abort and deferred load");
    applyStimulus(3'd0, 16'd10, 3);
    checkOutput("abort pre count", o_count, 8);
    i_mode_wr = 1'b1;
    i_mode_in = 3'd4;
    step();
    i_mode_wr = 1'b0;
    checkOutput("abort osa", o_osa, 0);
    checkOutput("abort c1", o_c1, 1);
    checkOutput("abort os", o_os, 1);
    pulseCe();
    pulseCe();
    pulseCe();
    checkOutput("abort wait count", o_count, 8);
    i_cnt_wr = 1'b1;
    i_cnt_in = 16'd5;
    i_ce     = 1'b1;
    step();
    i_cnt_wr = 1'b0;
    i_ce     = 1'b0;
    step();
    checkOutput("cnt_wr with ce count", o_count, 8);
    checkOutput("cnt_wr with ce osa", o_osa, 1);
    pulseCe();
    checkOutput("deferred load count", o_count, 5);

    $display("[TB] mode and count in one cycle");
    i_mode_wr = 1'b1;
    i_mode_in = 3'd2;
    i_cnt_wr  = 1'b1;
    i_cnt_in  = 16'd6;
    step();
    i_mode_wr = 1'b0;
    i_cnt_wr  = 1'b0;
    checkOutput("same cycle osa", o_osa, 1);
    checkOutput("same cycle p2", o_p2, 1);
    checkOutput("same cycle os", o_os, 0);
    pulseCe();
    checkOutput("same cycle load count", o_count, 6);
    pulseCe();
    checkOutput("same cycle dec count", o_count, 5);

    $display("[TB] randomized trials");
    modeList = '{0, 2, 3, 4, 6, 7};
    for (int t = 0; t < 24; t++) begin
      rawMode = modeList[$urandom_range(0, 5)];
      nVal    = $urandom_range(0, 12);
      kVal    = $urandom_range(1, 25);
      mMode   = (rawMode == 6) ? 2 : ((rawMode == 7) ? 3 : rawMode);
      applyStimulus(3'(rawMode), 16'(nVal), 0);
      for (int j = 0; j < kVal; j++) begin
        repeat ($urandom_range(0, 2)) step();
        pulseCe();
        refModel(mMode, nVal, j, eCnt, eC1, eCh);
        checkOutput($sformatf("rand m%0d n%0d j%0d count", rawMode, nVal, j), o_count, eCnt);
        checkOutput($sformatf("rand m%0d n%0d j%0d c1", rawMode, nVal, j), o_c1, eC1);
        checkOutput($sformatf("rand m%0d n%0d j%0d ch", rawMode, nVal, j), o_ch, eCh);
      end
    end

    $display("[TB] mode 4 with N=0");
    applyStimulus(3'd4, 16'd0, 0);
    i_ce = 1'b1;
    repeat (65536) step();
    checkOutput("m4 n0 before strobe count", o_count, 1);
    checkOutput("m4 n0 before strobe c1", o_c1, 1);
    step();
    checkOutput("m4 n0 strobe count", o_count, 0);
    checkOutput("m4 n0 strobe c1", o_c1, 0);
    step();
    i_ce = 1'b0;
    checkOutput("m4 n0 after strobe c1", o_c1, 1);
    checkOutput("m4 n0 after strobe count", o_count, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
